// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus master: default widths, region map, FSM encoding.
// No logic; the region helper is a pure function.
// No flow control here.
package mem_bus_master_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] RAM_REGION = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Same map the bus-side decoder uses: top two address bits select RAM.
    function automatic logic is_ram(input logic [1:0] top_bits);
        return top_bits == RAM_REGION;
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable 4-bit wait-state down-counter; saturates at zero.
// Load and decrement take effect at the next edge; zero is combinational from the count.
// No backpressure; decrement at zero is ignored.
module mem_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side bus initiator: one SETUP/ACCESS/DONE bus cycle per request; ROM_WP_EN rejects ROM writes.
// Latency: ack W+2 cycles after acceptance (W = region wait states), 1 cycle for a rejected write.
// Backpressure: req is only sampled in IDLE; requests arriving while busy are dropped.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROM_WAIT = 2,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              rd,
    output logic              wr,
    input  logic [DATA_W-1:0] data_in
);

    localparam logic [3:0] ROM_LD = 4'(ROM_WAIT - 1);
    localparam logic [3:0] RAM_LD = 4'(RAM_WAIT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              reject;
    logic              cnt_load, cnt_dec, cnt_zero;

`ifdef ROM_WP_EN
    assign reject = we && !is_ram(req_addr[ADDR_W-1 -: 2]);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_out_q <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_out_q <= data_out_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = reject ? DONE : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cnt_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data sampling on the last ACCESS cycle.
    always_comb begin
        addr_d     = addr_q;
        data_out_d = data_out_q;
        we_d       = we_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        if (state_q == IDLE && req) begin
            addr_d     = req_addr;
            data_out_d = wdata;
            we_d       = we;
            err_d      = reject;
        end
        if (state_q == ACCESS && cnt_zero && !we_q) begin
            rdata_d = data_in;
        end
    end

    always_comb begin
        rd       = 1'b0;
        wr       = 1'b0;
        data_oe  = 1'b0;
        ack      = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            SETUP: begin
                data_oe  = we_q;
                cnt_load = 1'b1;
            end
            ACCESS: begin
                rd      = ~we_q;
                wr      = we_q;
                data_oe = we_q;
                cnt_dec = 1'b1;
            end
            DONE:    ack = 1'b1;
            default: ;
        endcase
    end

    mem_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (is_ram(addr_q[ADDR_W-1 -: 2]) ? RAM_LD : ROM_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

`ifdef ROM_WP_EN
    assign err = ack & err_q;
`else
    assign err = 1'b0;
`endif

    assign addr     = addr_q;
    assign data_out = data_out_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with default widths and wait states (ROM 2, RAM 1).
// Cycle c is sampled 1 time unit after clock edge c-1, where edge 0 is the edge that accepts req.
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [12:0] req_addr;
    logic [7:0]  wdata;
    logic        ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic [12:0] addr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        rd;
    logic        wr;
    logic [7:0]  data_in;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [12:0] a;
        logic [7:0]  wd;
        logic [7:0]  din;
        int          ack_cyc;
        int          strobes;
        logic        err;
        logic [7:0]  rdata;
    } vec_t;

    typedef struct {
        int         ack_cyc;
        int         strobes;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    mem_bus_master #(
        .ADDR_W   (13),
        .DATA_W   (8),
        .ROM_WAIT (2),
        .RAM_WAIT (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .req_addr (req_addr),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .addr     (addr),
        .data_out (data_out),
        .data_oe  (data_oe),
        .rd       (rd),
        .wr       (wr),
        .data_in  (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        bit   seen;
        int   strb, first, wrong, dbad, busybad;
        @(negedge clk);
        req      = 1'b1;
        we       = v.we;
        req_addr = v.a;
        wdata    = v.wd;
        data_in  = v.din;
        e = '{v.ack_cyc, v.strobes, v.err, v.rdata};
        sb.push_back(e);
        @(posedge clk);
        #1;
        req      = 1'b0;
        req_addr = ~v.a;
        wdata    = ~v.wd;
        seen = 0; strb = 0; first = 0; wrong = 0; dbad = 0; busybad = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            if (rd || wr) begin
                strb++;
                if (first == 0) first = c;
            end
            if (v.we ? rd : wr) wrong++;
            if (data_oe && !(wr || (c == 1 && v.we && v.strobes > 0))) wrong++;
            if (wr && (data_out !== v.wd || !data_oe || addr !== v.a)) dbad++;
            if (rd && addr !== v.a) dbad++;
            if (!busy) busybad++;
            if (ack) begin
                seen = 1;
                got = sb.pop_front();
                chk("ack_cycle", c, got.ack_cyc);
                chk("rdata", rdata, got.rdata);
                chk("err", err, got.err);
                chk("strobe_cycles", strb, got.strobes);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("ack_seen", seen, 1);
        if (!seen) void'(sb.pop_front());
        if (v.strobes > 0) chk("first_strobe_cycle", first, 2);
        chk("strobe_kind", wrong, 0);
        chk("bus_drive", dbad, 0);
        chk("busy_during_op", busybad, 0);
        @(posedge clk);
        #1;
        chk("ack_single_pulse", {ack, busy, rd, wr, data_oe}, 0);
    endtask

    initial begin
        int   acks;
        exp_t e;
        exp_t got;

        tbl[0] = '{1'b0, 13'h1804, 8'h00, 8'hA5, 3, 1, 1'b0, 8'hA5};
        tbl[1] = '{1'b0, 13'h0010, 8'h00, 8'h3C, 4, 2, 1'b0, 8'h3C};
        tbl[2] = '{1'b1, 13'h1FFF, 8'h5A, 8'h77, 3, 1, 1'b0, 8'h3C};
`ifdef ROM_WP_EN
        tbl[3] = '{1'b1, 13'h1000, 8'h99, 8'h66, 1, 0, 1'b1, 8'h3C};
`else
        tbl[3] = '{1'b1, 13'h1000, 8'h99, 8'h66, 4, 2, 1'b0, 8'h3C};
`endif
        tbl[4] = '{1'b0, 13'h1800, 8'h00, 8'h0F, 3, 1, 1'b0, 8'h0F};
        tbl[5] = '{1'b0, 13'h17FF, 8'h00, 8'hF0, 4, 2, 1'b0, 8'hF0};
        tbl[6] = '{1'b1, 13'h1800, 8'h81, 8'h22, 3, 1, 1'b0, 8'hF0};

        rst = 1'b1; req = 1'b0; we = 1'b0; req_addr = '0; wdata = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {ack, err, busy, rd, wr, data_oe}, 0);
        chk("reset_addr", addr, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_rdata", rdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // req held high through a ROM read; second request (RAM) accepted in cycle 5.
        @(negedge clk);
        req = 1'b1; we = 1'b0; req_addr = 13'h0010; data_in = 8'h3C;
        e = '{4, 0, 1'b0, 8'h3C}; sb.push_back(e);
        e = '{8, 0, 1'b0, 8'hA5}; sb.push_back(e);
        acks = 0;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (c == 1) req_addr = 13'h1804;
            if (c == 2) chk("held_req_addr_first", addr, 13'h0010);
            if (c == 7) chk("held_req_addr_second", addr, 13'h1804);
            if (ack) begin
                acks++;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk("held_req_ack_cycle", c, got.ack_cyc);
                    chk("held_req_rdata", rdata, got.rdata);
                end
            end
            if (c == 5) data_in = 8'hA5;
            if (c == 6) req = 1'b0;
            @(posedge clk);
        end
        #1;
        chk("held_req_ack_count", acks, 2);

        // Reset asserted in cycle 2 of a ROM read aborts it without an ack.
        @(negedge clk);
        req = 1'b1; we = 1'b0; req_addr = 13'h0010; data_in = 8'h11;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rd_before_rst", rd, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_outputs", {rd, busy, ack}, 0);
        chk("abort_addr", addr, 0);
        chk("abort_rdata", rdata, 0);
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (ack || busy) acks++;
        end
        chk("abort_no_ack", acks, 0);

        // rst and req together: request discarded.
        @(negedge clk);
        rst = 1'b1; req = 1'b1; we = 1'b0; req_addr = 13'h1804;
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0;
        chk("rst_req_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("rst_req_idle", {busy, ack, rd}, 0);

        run_vec('{1'b0, 13'h1804, 8'h00, 8'hC3, 3, 1, 1'b0, 8'hC3});

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

CPU-side initiator for the 13-bit instruction/data memory bus. Accepts single read or write requests from the core and runs one bus cycle per request. Each cycle drives the address, data and rd/wr strobes, inserts region-dependent wait states and returns read data with an ack pulse. It classifies addresses into ROM and RAM regions with the same map the bus-side address decoder uses, so strobe timing matches the selected device.

## Interface
Parameters:
- ADDR_W, 13, bus address width
- DATA_W, 8, bus data width
- ROM_WAIT, 2, ACCESS cycles for a ROM-region access (legal range 1..15)
- RAM_WAIT, 1, ACCESS cycles for a RAM-region access (legal range 1..15)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  request strobe from core, sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- req_addr  in  ADDR_W  request address; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- ack  out  1  one-cycle pulse, request complete
- err  out  1  valid with ack; 1 = request rejected
- rdata  out  DATA_W  read data; valid with ack, held until next ack
- busy  out  1  high from the cycle after acceptance through the ack cycle
- addr  out  ADDR_W  bus address
- data_out  out  DATA_W  bus write data
- data_oe  out  1  bus write-data enable
- rd  out  1  bus read strobe
- wr  out  1  bus write strobe
- data_in  in  DATA_W  bus read data

## Operation
- Region map on the latched address:
  - addr[12:11] == 2'b11 → RAM.
  - Otherwise → ROM.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - req=1 latches we, req_addr and wdata.
  - If the request is a rejected ROM write (see Configuration), go to DONE with err=1.
  - Otherwise go to SETUP.
  - req=0 stays in IDLE.
- SETUP:
  - addr and data_out are driven.
  - data_oe = we.
  - rd = wr = 0.
  - Wait counter loads W-1, where W is ROM_WAIT or RAM_WAIT by region.
  - Go to ACCESS.
- ACCESS:
  - rd = ~we, wr = we, data_oe = we.
  - Counter decrements each cycle.
  - When the counter reaches 0, a read samples data_in into rdata and the FSM goes to DONE.
- DONE:
  - ack=1, rd=wr=data_oe=0.
  - addr holds its value.
  - Go to IDLE.
- req is ignored whenever the FSM is not in IDLE; dropped requests are not queued.
- Back-to-back operation: req may be high in the cycle after ack, because the FSM is then in IDLE.
- Writes leave rdata unchanged.
- err=0 on every successful ack.

## Timing
- Reset values:
  - ack, err, busy, rd, wr and data_oe are 0.
  - addr, data_out and rdata are all zeros.
  - FSM is in IDLE and the counter is 0.
- Latency, with req sampled at edge 0:
  - SETUP in cycle 1.
  - ACCESS in cycles 2..1+W.
  - ack in cycle 2+W.
  - Result: a RAM read acks in cycle 3, a ROM read in cycle 4.
- Rejected write: ack=err=1 in cycle 1, and no strobe is ever asserted.
- rd/wr are high for exactly W consecutive cycles, never in SETUP or DONE.
- rst asserted mid-cycle:
  - At the next edge, all outputs take their reset values and the FSM returns to IDLE.
  - No ack is issued for the aborted request.
- rst and req high together: rst wins and the request is discarded.

## Configuration
- ROM_WP_EN defined: a write to the ROM region is rejected. It completes with ack=1, err=1 one cycle after acceptance and performs no bus cycle.
- ROM_WP_EN undefined: ROM writes run a normal bus cycle with ROM_WAIT wait states, and err is tied to 0.

## Structure
- The shared package holds:
  - ADDR_W and DATA_W defaults.
  - The region-match constant RAM_REGION = 2'b11 on addr[12:11].
  - The FSM state encoding: IDLE=0, SETUP=1, ACCESS=2, DONE=3.
- One sub-module, mem_wait_cnt:
  - Loadable 4-bit down-counter with load, dec and zero outputs.
  - Instantiated once.
- The region decode stays inline.

## Test plan
- RAM read: req, we=0, req_addr=13'h1804, data_in=8'hA5 → rd high in cycles 2–2, ack in cycle 3, rdata=8'hA5, err=0.
- ROM read: req, we=0, req_addr=13'h0010, data_in=8'h3C → rd high in cycles 2–3, ack in cycle 4, rdata=8'h3C.
- RAM write: req, we=1, req_addr=13'h1FFF, wdata=8'h5A → wr and data_oe high in cycle 2, data_out=8'h5A, ack in cycle 3, rdata unchanged.
- ROM write:
  - With ROM_WP_EN, req_addr=13'h1000 → ack=err=1 in cycle 1, with rd, wr and data_oe 0 throughout.
  - Without ROM_WP_EN → wr high in cycles 2–3, ack in cycle 4, err=0.
- req held high during a ROM read:
  - The extra req in busy cycles is ignored.
  - A new request accepted in cycle 5 acks in cycle 8 (RAM).
- rst asserted in cycle 2 of a ROM read → rd, busy and addr are 0 in cycle 3, and no ack appears in the following 5 cycles.
